// File: rtl/stream_rr_arbiter.sv
`timescale 1ns / 1ps
// Round-robin, burst-locked N:1 stream arbiter.
// Merges NUM_IN FWFT read-side channels into one registered write-side stream.
// Each grant costs one IDLE bubble. A grant then moves up to MAX_BURST words.
// The grant ends early when its channel runs dry. Backpressure stalls a burst but never
// breaks it.
module stream_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned IDX_WIDTH   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
    localparam int unsigned BURST_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_IN-1:0]            in_empty_n,
    output logic [NUM_IN-1:0]            in_read,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_dout,
    input  logic                         out_full_n,
    output logic                         out_write,
    output logic [DATA_WIDTH-1:0]        out_din,
    output logic [IDX_WIDTH-1:0]         out_src,
    output logic                         grant_valid,
    output logic [IDX_WIDTH-1:0]         grant_idx
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StBurst = 1'b1;

    logic [0:0]             state_q,       state_d;
    logic [IDX_WIDTH-1:0]   rr_ptr_q,      rr_ptr_d;
    logic [BURST_WIDTH-1:0] burst_cnt_q,   burst_cnt_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [IDX_WIDTH-1:0]   grant_idx_q,   grant_idx_d;
    logic                   out_write_q,   out_write_d;
    logic [DATA_WIDTH-1:0]  out_din_q,     out_din_d;
    logic [IDX_WIDTH-1:0]   out_src_q,     out_src_d;

    logic [DATA_WIDTH-1:0]  dout_arr [NUM_IN];
    logic [DATA_WIDTH-1:0]  g_dout;
    logic                   g_valid;
    logic                   xfer;
    logic                   last_word;
    logic [IDX_WIDTH-1:0]   next_ptr;
    logic                   pick_found;
    logic [IDX_WIDTH-1:0]   pick_idx;
    int unsigned            cand;
    logic [IDX_WIDTH-1:0]   cand_idx;

    // Unpack the flat payload bus into one word per channel.
    always_comb begin
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            dout_arr[k] = in_dout[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Only the granted channel's payload and valid are looked at, so X elsewhere is harmless.
    always_comb begin
        g_dout    = dout_arr[grant_idx_q];
        g_valid   = in_empty_n[grant_idx_q];
        xfer      = (state_q == StBurst) && enable && g_valid && out_full_n;
        last_word = (burst_cnt_q == BURST_WIDTH'(MAX_BURST - 1));
        next_ptr  = (grant_idx_q == IDX_WIDTH'(NUM_IN - 1)) ? '0 : grant_idx_q + 1'b1;
    end

    // Find the first non-empty channel, scanning upward from rr_ptr and wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            cand_idx = IDX_WIDTH'(cand);
            if (!pick_found && in_empty_n[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state logic for grant, burst counting, output register and pop strobe.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        burst_cnt_d   = burst_cnt_q;
        grant_valid_d = grant_valid_q;
        grant_idx_d   = grant_idx_q;
        out_write_d   = 1'b0;
        out_din_d     = out_din_q;
        out_src_d     = out_src_q;
        in_read       = '0;

        case (state_q)
            StIdle: begin
                if (enable && pick_found) begin
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    burst_cnt_d   = '0;
                    state_d       = StBurst;
                end
            end
            StBurst: begin
                if (xfer) begin
                    in_read[grant_idx_q] = 1'b1;
                    out_write_d          = 1'b1;
                    out_din_d            = g_dout;
                    out_src_d            = grant_idx_q;
                    burst_cnt_d          = burst_cnt_q + 1'b1;
                end
                // Release after the final word of the burst, or once the channel runs dry.
                if ((xfer && last_word) || (enable && !g_valid)) begin
                    state_d       = StIdle;
                    grant_valid_d = 1'b0;
                    rr_ptr_d      = next_ptr;
                    burst_cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and registered outputs; reset takes effect immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            burst_cnt_q   <= '0;
            grant_valid_q <= 1'b0;
            grant_idx_q   <= '0;
            out_write_q   <= 1'b0;
            out_din_q     <= '0;
            out_src_q     <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            burst_cnt_q   <= burst_cnt_d;
            grant_valid_q <= grant_valid_d;
            grant_idx_q   <= grant_idx_d;
            out_write_q   <= out_write_d;
            out_din_q     <= out_din_d;
            out_src_q     <= out_src_d;
        end
    end

    assign out_write   = out_write_q;
    assign out_din     = out_din_q;
    assign out_src     = out_src_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
`timescale 1ns / 1ps
// Self-checking bench for stream_rr_arbiter (NUM_IN=4, MAX_BURST=4, DATA_WIDTH=32).
// Upstream FIFOs are bench queues. A per-cycle reference model predicts every output.
// Directed tables and sequences cover the corner cases.
module tb_stream_rr_arbiter;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            enable;
    logic [N-1:0]    in_empty_n;
    logic [N-1:0]    in_read;
    logic [N*DW-1:0] in_dout;
    logic            out_full_n;
    logic            out_write;
    logic [DW-1:0]   out_din;
    logic [IW-1:0]   out_src;
    logic            grant_valid;
    logic [IW-1:0]   grant_idx;

    stream_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_IN     (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .in_empty_n  (in_empty_n),
        .in_read     (in_read),
        .in_dout     (in_dout),
        .out_full_n  (out_full_n),
        .out_write   (out_write),
        .out_din     (out_din),
        .out_src     (out_src),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] fifo [N][$];
    int            src_log[$];
    logic [DW-1:0] dat_log[$];

    // Reference model state: whether a channel is granted, which one, words moved, scan start.
    int            m_busy, m_g, m_cnt, m_ptr, m_ow, m_os;
    logic [DW-1:0] m_od;

    // Snapshot of DUT outputs taken mid-cycle by tick().
    logic [N-1:0]  cap_read;
    logic          cap_write, cap_gv;
    logic [IW-1:0] cap_gidx;

    typedef struct packed {
        logic       en;
        logic       fn;
        logic [3:0] rd;
        logic       wr;
        logic       gv;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0; m_ow = 0; m_os = 0; m_od = '0;
    endtask

    task automatic end_grant();
        m_busy = 0;
        m_ptr  = (m_g + 1) % N;
        m_cnt  = 0;
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (fifo[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Present queue heads as FWFT outputs; empty channels show X.
    task automatic drive();
        in_empty_n = '0;
        in_dout    = 'x;
        for (int k = 0; k < N; k++) begin
            if (fifo[k].size() != 0) begin
                in_empty_n[k]          = 1'b1;
                in_dout[k*DW +: DW]    = fifo[k][0];
            end
        end
    endtask

    // Compare DUT against the model, then advance the model by one clock.
    task automatic model_step();
        logic [N-1:0] er;
        bit found;
        int k;
        er = '0;
        if (reset_n && m_busy != 0 && enable && fifo[m_g].size() != 0 && out_full_n)
            er[m_g] = 1'b1;
        check("in_read", in_read, er);
        check("grant_valid", grant_valid, m_busy);
        check("grant_idx", grant_idx, m_g);
        check("out_write", out_write, m_ow);
        check("out_din", out_din, m_od);
        check("out_src", out_src, m_os);
        if (!reset_n) begin
            model_reset();
        end else if (m_busy == 0) begin
            m_ow  = 0;
            found = 1'b0;
            if (enable) begin
                for (int o = 0; o < N; o++) begin
                    k = (m_ptr + o) % N;
                    if (!found && fifo[k].size() != 0) begin
                        found  = 1'b1;
                        m_busy = 1;
                        m_g    = k;
                        m_cnt  = 0;
                    end
                end
            end
        end else if (er[m_g]) begin
            m_ow = 1;
            m_od = fifo[m_g][0];
            m_os = m_g;
            m_cnt++;
            if (m_cnt == MB) end_grant();
        end else begin
            m_ow = 0;
            if (enable && fifo[m_g].size() == 0) end_grant();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cap_read  = in_read;
        cap_write = out_write;
        cap_gv    = grant_valid;
        cap_gidx  = grant_idx;
        if (out_write) begin
            src_log.push_back(int'(out_src));
            dat_log.push_back(out_din);
        end
        model_step();
        @(posedge clk);
        #1;
        if (reset_n) begin
            for (int k = 0; k < N; k++) if (cap_read[k]) void'(fifo[k].pop_front());
        end
        drive();
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) fifo[k].delete();
        src_log.delete();
        dat_log.delete();
        model_reset();
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        enable     = 1'b1;
        out_full_n = 1'b1;
        clear_all();
        drive();
        repeat (3) tick();
        check("rst_out_write", out_write, 0);
        check("rst_out_din", out_din, 0);
        check("rst_out_src", out_src, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_in_read", in_read, 0);
        reset_n = 1'b1;
    endtask

    task automatic push_words(input int ch, input int n);
        for (int i = 0; i < n; i++) fifo[ch].push_back(DW'((ch << 24) | i));
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            tick();
            n++;
            done = all_empty() && !grant_valid && !out_write;
        end
        check(name, done, 1);
    endtask

    task automatic check_src_seq(input string name, input int exp_src[$]);
        check({name, "_len"}, src_log.size(), exp_src.size());
        for (int i = 0; i < exp_src.size() && i < src_log.size(); i++)
            check(name, src_log[i], exp_src[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_q[$];
        int n;
        reset_n    = 1'b0;
        enable     = 1'b0;
        out_full_n = 1'b1;
        in_empty_n = '0;
        in_dout    = '0;
        model_reset();
        #1;

        // Table for a single channel: ch2 holds 10 words, no stalls.
        tbl[0]  = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'b0100, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 4'b0100, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 4'b0100, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 4'b0100, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 4'b0000, 1'b1, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};

        // Reset then idle.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_read", cap_read, 0);
        end

        // Single channel, table driven.
        do_reset();
        push_words(2, 10);
        drive();
        for (int i = 0; i < 15; i++) begin
            enable     = tbl[i].en;
            out_full_n = tbl[i].fn;
            drive();
            tick();
            check("tbl_read", cap_read, tbl[i].rd);
            check("tbl_write", cap_write, tbl[i].wr);
            check("tbl_gv", cap_gv, tbl[i].gv);
        end
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(2);
        check_src_seq("single_src", exp_q);
        for (int i = 0; i < 10 && i < dat_log.size(); i++)
            check("single_data", dat_log[i], DW'((2 << 24) | i));

        // Round robin over four full channels.
        do_reset();
        for (int k = 0; k < N; k++) push_words(k, 8);
        drive();
        drain("rr_drain", 200);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back((i / 4) % 4);
        check_src_seq("rr_src", exp_q);

        // Backpressure for 5 cycles mid-burst.
        do_reset();
        push_words(1, 8);
        drive();
        repeat (3) tick();
        out_full_n = 1'b0;
        drive();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_read", cap_read, 0);
            check("bp_gv", cap_gv, 1);
        end
        out_full_n = 1'b1;
        drive();
        drain("bp_drain", 50);
        check("bp_count", dat_log.size(), 8);
        for (int i = 0; i < 8 && i < dat_log.size(); i++)
            check("bp_data", dat_log[i], DW'((1 << 24) | i));

        // Early termination and wrap of the scan.
        do_reset();
        push_words(0, 2);
        push_words(3, 5);
        drive();
        drain("early_drain", 50);
        exp_q = '{0, 0, 3, 3, 3, 3, 3};
        check_src_seq("early_src", exp_q);

        // Enable freeze mid-burst: two words moved, three frozen cycles, two more words.
        do_reset();
        push_words(1, 8);
        drive();
        repeat (3) tick();
        enable = 1'b0;
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_read", cap_read, 0);
            check("frz_gidx", cap_gidx, 1);
            check("frz_gv", cap_gv, 1);
        end
        enable = 1'b1;
        drive();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!cap_gv) break;
            if (cap_read[1]) n++;
        end
        check("frz_resume_words", n, 2);
        drain("frz_drain", 50);

        // Asynchronous reset between edges during a ch1 burst.
        do_reset();
        push_words(1, 8);
        drive();
        repeat (4) tick();
        check("pre_rst_write", out_write, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_write", out_write, 0);
        check("async_read", in_read, 0);
        check("async_gv", grant_valid, 0);
        clear_all();
        drive();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 99) < 15) fifo[k].push_back($urandom);
            enable     = ($urandom_range(0, 99) < 90);
            out_full_n = ($urandom_range(0, 99) < 75);
            drive();
        end
        enable     = 1'b1;
        out_full_n = 1'b1;
        drive();
        drain("rand_drain", 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Round-robin, burst-locked N:1 arbiter merging NUM_IN first-word-fall-through (FWFT) stream channels into one stream.
- Each input is the read side of an FWFT FIFO or relay station: empty_n / read / dout.
- The output drives the write side of a downstream almost-full relay station: full_n / write / din.
- The output is registered, so the merge point can sit on a floorplan slot boundary. The downstream grace period absorbs the 1-cycle full_n reaction delay.

Parameters:
- DATA_WIDTH, 32, payload width per channel.
- NUM_IN, 4, number of input channels; must be >= 1.
- IDX_WIDTH, (NUM_IN>1 ? $clog2(NUM_IN) : 1), derived; width of channel index.
- MAX_BURST, 4, maximum words granted to one channel before forced rotation; must be >= 1.
- BURST_WIDTH, $clog2(MAX_BURST+1), derived; width of the burst counter.

Ports:
- clk, input, 1, clock; all state updates on posedge.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, 1 = arbitration and transfers allowed; 0 = freeze (no reads, no grants).
- in_empty_n, input, NUM_IN, per-channel data-valid (FWFT).
- in_read, output, NUM_IN, per-channel pop strobe; combinational; one-hot or zero.
- in_dout, input, NUM_IN*DATA_WIDTH, channel k payload in bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_full_n, input, 1, downstream not-almost-full.
- out_write, output, 1, registered write strobe.
- out_din, output, DATA_WIDTH, registered payload.
- out_src, output, IDX_WIDTH, registered source channel index of the out_din word.
- grant_valid, output, 1, registered; 1 while in BURST.
- grant_idx, output, IDX_WIDTH, registered; currently granted channel.

Behaviour:
- Reset (reset_n low, async, applies immediately):
  - state=IDLE, rr_ptr=0, burst_cnt=0.
  - out_write=0, out_din=0, out_src=0, grant_valid=0, grant_idx=0.
  - in_read=0 while reset_n is low.
- State IDLE:
  - in_read=0.
  - If enable=1 and any in_empty_n bit is set: pick the first set bit scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_IN.
  - Then grant_idx<=k, grant_valid<=1, burst_cnt<=0, state<=BURST.
  - Otherwise remain in IDLE.
  - IDLE costs exactly 1 bubble cycle per grant.
- State BURST, granted channel g:
  - xfer = enable & in_empty_n[g] & out_full_n.
  - in_read[g] = xfer; all other in_read bits are 0.
  - On xfer: out_write<=1, out_din<=in_dout[g], out_src<=g, burst_cnt<=burst_cnt+1.
  - Without xfer: out_write<=0; out_din and out_src hold.
- Leaving BURST (goes to IDLE, grant_valid<=0, rr_ptr<=(g+1) mod NUM_IN, burst_cnt<=0) when either:
  - (a) xfer and burst_cnt==MAX_BURST-1, i.e. the final word of the burst has moved; or
  - (b) enable=1 and in_empty_n[g]=0, i.e. the channel ran dry.
- Backpressure:
  - out_full_n=0 with in_empty_n[g]=1: remain in BURST, counter holds, no read.
  - A burst is never broken by backpressure.
- enable=0: no reads, no state transitions, counters hold; out_write<=0 next cycle.
- Ordering:
  - Per-channel word order is preserved.
  - Each popped word appears on out_din exactly once, exactly 1 cycle after its in_read pulse.
- Fairness:
  - After a channel's grant ends, every other channel holding data is granted before it is granted again.
  - Worst-case wait is (NUM_IN-1)*(MAX_BURST+1) cycles of unstalled output.
- NUM_IN=1: rr_ptr stays 0; behaviour otherwise identical.
- MAX_BURST=1: strict word-interleave; alternates IDLE/BURST, peak throughput 1/2.
- Reset mid-burst:
  - Any word popped before reset and not yet presented is lost; out_write drops immediately.
  - The upstream FIFOs are reset by the same reset.
- in_dout of non-granted channels is ignored; X on them must not propagate.

Test Plan:
- Reset then idle: reset_n low 3 cycles, all in_empty_n=0 -> all outputs 0; in_read=0 for 10 cycles after release.
- Single channel: NUM_IN=4, MAX_BURST=4, ch2 holds 10 words, out_full_n=1 -> grant after 1 bubble; output pattern 4 words, bubble, 4 words, bubble, 2 words; out_src=2 throughout; data in order, 1 cycle after each in_read.
- Round-robin: channels 0-3 each hold 8 words -> out_src sequence 0×4, 1×4, 2×4, 3×4, 0×4, 1×4, 2×4, 3×4; each burst is separated by 1 bubble.
- Backpressure: ch1 streaming, out_full_n=0 for 5 cycles mid-burst -> in_read[1]=0 for those 5 cycles; burst_cnt frozen; burst completes after release; no word lost or duplicated.
- Early termination: ch0 holds 2 words, ch3 holds 5, MAX_BURST=4 -> ch0 ×2, IDLE, ch3 ×4, IDLE, ch3 ×1 (ch0 empty, so scan wraps).
- Async reset mid-burst and enable freeze: pull reset_n low between clock edges during a ch1 burst -> out_write=0 and in_read=0 before the next edge. Separately, deassert enable for 3 cycles mid-burst -> no reads; grant_idx unchanged; resumes with the same burst count.
